// File: rtl/fsqrt_share_arb.sv
// Round-robin sharing wrapper for one pipelined fsqrt core: tags each issued operand and
// returns results in issue order through a show-ahead FIFO. Optional FSQRT_SHARE_ARB_STATS_EN adds issue/stall counters.
module fsqrt_share_arb #(
    parameter int NREQ  = 4,
    parameter int W     = 9,
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    localparam int TW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      sq_x,
    input  logic [W-1:0]      sq_r,
    output logic              rsp_valid,
    output logic [TW-1:0]     rsp_tag,
    output logic [W-1:0]      rsp_data,
`ifdef FSQRT_SHARE_ARB_STATS_EN
    output logic [15:0]       stat_issue,
    output logic [15:0]       stat_stall,
`endif
    input  logic              rsp_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + LAT + 2);

    logic [TW-1:0] last_q, last_d;
    logic [W-1:0]  sq_x_q, sq_x_d;
    logic [LAT:0]  vld_q;
    logic [TW-1:0] tag_q [LAT+1];

    logic [W-1:0]  mem_data [DEPTH];
    logic [TW-1:0] mem_tag  [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] inflight, credit;
    logic          issue_ok, found, push, pop;
    logic [TW-1:0] win;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts every op already accepted but not yet popped; pops in this cycle do not free credit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(vld_q[i]);
        credit   = count_q + inflight;
        issue_ok = rst_n && (credit < CW'(DEPTH));
    end

    // NOTE: every variable in a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        if (issue_ok) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
                    found = 1'b1;
                    win   = TW'((int'(last_q) + k) % NREQ);
                end
            end
        end
        req_ready = found ? (NREQ'(1) << win) : '0;
        last_d    = win;
        sq_x_d    = found ? req_data[int'(win)*W +: W] : sq_x_q;
    end

    assign sq_x = sq_x_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= TW'(NREQ - 1);
            sq_x_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
        end else begin
            last_q   <= last_d;
            sq_x_q   <= sq_x_d;
            vld_q    <= {vld_q[LAT-1:0], found};
            tag_q[0] <= win;
            for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Stage LAT is valid exactly when the core output belongs to a live op.
    assign push      = vld_q[LAT];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr_q] : '0;
    assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr_q]  : '0;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    // NOTE: storage is not reset; outputs are gated by rsp_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= sq_r;
            mem_tag[wr_ptr_q]  <= tag_q[LAT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) assert (count_q != CW'(DEPTH));
    end

`ifdef FSQRT_SHARE_ARB_STATS_EN
    logic [15:0] stat_issue_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (found && stat_issue_q != 16'hFFFF) stat_issue_q <= stat_issue_q + 16'd1;
            if ((|req_valid) && !found && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fsqrt_share_arb.sv
// Self-checking bench for fsqrt_share_arb: behavioural fsqrt core stand-in plus a transaction-level
// reference model (credit = accepted - popped, in-order result queue with availability times).
module tb_fsqrt_share_arb;

    localparam int NREQ  = 4;
    localparam int W     = 9;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int TW    = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      sq_x;
    logic [W-1:0]      sq_r;
    logic              rsp_valid;
    logic [TW-1:0]     rsp_tag;
    logic [W-1:0]      rsp_data;
    logic              rsp_ready = 1'b0;
`ifdef FSQRT_SHARE_ARB_STATS_EN
    logic [15:0]       stat_issue, stat_stall;
`endif

    fsqrt_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sq_x      (sq_x),
        .sq_r      (sq_r),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
`ifdef FSQRT_SHARE_ARB_STATS_EN
        .stat_issue(stat_issue),
        .stat_stall(stat_stall),
`endif
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    // Square root on the 9-bit format: exc[8:7] sign[6] exp[5:3] (bias 3) frac[2:0], truncating.
    function automatic logic [8:0] fsqrt_ref(input logic [8:0] x);
        int m, v, r, e;
        logic [2:0] eo;
        case (x[8:7])
            2'b00: return {2'b00, x[6], 6'b0};
            2'b10: return x[6] ? 9'h180 : 9'h100;
            2'b11: return 9'h180;
            default: begin
                if (x[6]) return 9'h180;
                m = 8 + int'(x[2:0]);
                e = int'(x[5:3]);
                if (e % 2 == 1) begin v = 8 * m;  eo = 3'((e + 3) / 2); end
                else            begin v = 16 * m; eo = 3'((e + 2) / 2); end
                r = 0;
                while ((r + 1) * (r + 1) <= v) r++;
                return {2'b01, 1'b0, eo, 3'(r % 8)};
            end
        endcase
    endfunction

    logic [W-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= fsqrt_ref(sq_x);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign sq_r = core_pipe[LAT-1];

    typedef struct {
        int           tag;
        logic [W-1:0] data;
        int           avail;
    } exp_t;

    exp_t q[$];
    int   m_last, m_cnt, cyc, m_issue, m_stall;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [NREQ*W-1:0] pack1(input int idx, input logic [W-1:0] val);
        logic [NREQ*W-1:0] d;
        d = '0;
        d[idx*W +: W] = val;
        return d;
    endfunction

    function automatic logic [NREQ*W-1:0] pack_all(input logic [W-1:0] val);
        logic [NREQ*W-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*W +: W] = val;
        return d;
    endfunction

    function automatic logic [NREQ*W-1:0] pack_rand();
        logic [NREQ*W-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt   = 0;
        m_last  = NREQ - 1;
        m_issue = 0;
        m_stall = 0;
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance the model.
    task automatic do_cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d, input logic rr);
        int win;
        logic [NREQ-1:0] eg;
        bit ev;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        @(negedge clk);
        win = -1;
        if (m_cnt < DEPTH)
            for (int k = 1; k <= NREQ; k++)
                if (win < 0 && v[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check("grant", 32'(req_ready), 32'(eg));
        ev = (q.size() > 0) && (q[0].avail <= cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            check("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
            check("rsp_data", 32'(rsp_data), 32'(q[0].data));
        end
`ifdef FSQRT_SHARE_ARB_STATS_EN
        check("stat_issue", 32'(stat_issue), 32'(m_issue));
        check("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
        if (win >= 0) begin
            q.push_back('{tag: win, data: fsqrt_ref(d[win*W +: W]), avail: cyc + LAT + 2});
            m_last = win;
            m_cnt++;
            if (m_issue < 16'hFFFF) m_issue++;
        end else if (|v) begin
            if (m_stall < 16'hFFFF) m_stall++;
        end
        if (ev && rr) begin
            void'(q.pop_front());
            m_cnt--;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_sq_x", 32'(sq_x), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int acc;
        int thr;
        cyc = 0;
        model_reset();
        do_reset();

        // Lone request and exception pass-through.
        do_cycle(4'b0001, pack1(0, 9'h098), 1'b1);
        repeat (3) do_cycle('0, '0, 1'b1);
        do_cycle(4'b0100, pack1(2, 9'h0D8), 1'b1);
        do_cycle(4'b0100, pack1(2, 9'h000), 1'b1);
        repeat (4) do_cycle('0, '0, 1'b1);

        // Full contention from a fresh pointer.
        do_reset();
        repeat (5) do_cycle(4'hF, pack_all(9'h0A8), 1'b1);
        repeat (4) do_cycle('0, '0, 1'b1);

        // Credit limit with a stalled consumer, then one pop frees one slot.
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b0010, pack1(1, 9'h0B8), 1'b0);
            acc += int'(req_ready[1]);
        end
        check("credit_accepts", 32'(acc), 32'(DEPTH));
        do_cycle(4'b0010, pack1(1, 9'h0B8), 1'b1);
        do_cycle(4'b0010, pack1(1, 9'h0B8), 1'b0);
        check("credit_regrant", 32'(req_ready[1]), 32'd1);
        repeat (6) do_cycle('0, '0, 1'b1);

        // Reset with two ops in flight and two in the FIFO.
        repeat (4) do_cycle(4'hF, pack_all(9'h0A8), 1'b0);
        do_reset();
        do_cycle(4'b0011, pack_all(9'h0C8), 1'b1);
        repeat (4) do_cycle('0, '0, 1'b1);

        // Randomized traffic with varying back-pressure and one mid-run reset.
        thr = 7;
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) thr = int'($urandom_range(0, 10));
            if (i == 750) do_reset();
            do_cycle(NREQ'($urandom), pack_rand(), ($urandom_range(0, 9) < thr));
        end
        repeat (12) do_cycle('0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
